// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM timing/duty source.
package pwm_pkg;

    localparam int CLK_IN_HZ  = 100_000_000;
    localparam int TICK_HZ    = 5_000_000;
    localparam int DIV        = CLK_IN_HZ / TICK_HZ;
    localparam int DUTY_W     = 13;
    localparam int PERIOD     = 5000;
    localparam int DUTY_RESET = 0;
    localparam int LOCK_TICKS = 16;

    typedef logic [DUTY_W-1:0] duty_t;

    // Saturates a requested duty to the last valid compare value of a period.
    function automatic duty_t clamp_duty(input duty_t req, input duty_t max_duty);
        return (req > max_duty) ? max_duty : req;
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Tick divider: div_cnt produces the single-cycle tick, per_cnt counts ticks
// per PWM period and flags the tick that opens each period.
module pwm_tick_div
    import pwm_pkg::*;
#(
    parameter int TICK_DIV    = 20,
    parameter int PERIOD_TICK = 5000
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic o_tick,
    output logic o_period_start,
    output logic o_period_load
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]  r_div_cnt;
    logic [DUTY_W-1:0] r_per_cnt;
    logic              r_first;
    logic              r_tick;
    logic              r_period_start;
    logic              w_div_wrap;
    logic              w_per_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_W'(TICK_DIV - 1));
    // The very first tick after reset opens a period just like a wrap does.
    assign w_per_wrap = r_first || (r_per_cnt == DUTY_W'(PERIOD_TICK - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt      <= '0;
            r_per_cnt      <= '0;
            r_first        <= 1'b1;
            r_tick         <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_tick         <= w_div_wrap;
            r_period_start <= w_div_wrap && w_per_wrap;
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_first   <= 1'b0;
                r_per_cnt <= w_per_wrap ? '0 : r_per_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign o_tick         = r_tick;
    assign o_period_start = r_period_start;
    assign o_period_load  = w_div_wrap && w_per_wrap;

endmodule

// File: rtl/pwm_clk_duty_src.sv
// PWM timing/duty source: 5 MHz tick, period boundary flag, glitch-free duty
// hand-off and lock indication. DUTY_CLAMP_EN saturates writes to PERIOD-1.
module pwm_clk_duty_src
    import pwm_pkg::*;
#(
    parameter int CLK_IN_HZ  = pwm_pkg::CLK_IN_HZ,
    parameter int TICK_HZ    = pwm_pkg::TICK_HZ,
    parameter int PERIOD     = pwm_pkg::PERIOD,
    parameter int DUTY_RESET = pwm_pkg::DUTY_RESET,
    parameter int LOCK_TICKS = pwm_pkg::LOCK_TICKS
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              duty_wr_en,
    input  logic [DUTY_W-1:0] duty_wr_data,
    output logic              tick_5mhz,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_cnt,
    output logic              locked
);

    localparam int    TICK_DIV   = CLK_IN_HZ / TICK_HZ;
    localparam int    LOCK_W     = (LOCK_TICKS > 2) ? $clog2(LOCK_TICKS) : 1;
    localparam duty_t DUTY_RST   = duty_t'(DUTY_RESET);
    localparam duty_t DUTY_LIMIT = duty_t'(PERIOD - 1);

    if ((CLK_IN_HZ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_bad_div
        $error("CLK_IN_HZ/TICK_HZ must be an integer >= 2");
    end
    if (PERIOD < 1 || PERIOD > (1 << DUTY_W)) begin : g_bad_period
        $error("PERIOD must lie in 1..2**DUTY_W");
    end
    if (LOCK_TICKS < 1) begin : g_bad_lock
        $error("LOCK_TICKS must be >= 1");
    end

    logic              w_tick;
    logic              w_period_start;
    logic              w_period_load;
    duty_t             w_wr_duty;
    duty_t             r_shadow;
    duty_t             r_duty;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;

    pwm_tick_div #(
        .TICK_DIV    (TICK_DIV),
        .PERIOD_TICK (PERIOD)
    ) u_tick_div (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .o_tick         (w_tick),
        .o_period_start (w_period_start),
        .o_period_load  (w_period_load)
    );

`ifdef DUTY_CLAMP_EN
    assign w_wr_duty = clamp_duty(duty_wr_data, DUTY_LIMIT);
`else
    assign w_wr_duty = duty_wr_data;
`endif

    // NOTE: every register here, including the duty holding registers, has an
    // explicit reset value because the outputs must be defined from release.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= DUTY_RST;
            r_duty     <= DUTY_RST;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (duty_wr_en) begin
                r_shadow <= w_wr_duty;
            end
            // Loading DUTY_RST while unlocked keeps duty_cnt forced and still
            // only lets it change on a period boundary.
            if (w_period_load) begin
                r_duty <= r_locked ? r_shadow : DUTY_RST;
            end
            if (w_tick && !r_locked) begin
                if (r_lock_cnt == LOCK_W'(LOCK_TICKS - 1)) begin
                    r_locked <= 1'b1;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end
        end
    end

    assign tick_5mhz    = w_tick;
    assign period_start = w_period_start;
    assign duty_cnt     = r_duty;
    assign locked       = r_locked;

    // DUTY_LIMIT is only consumed by the clamping build.
    logic w_unused;
    assign w_unused = ^DUTY_LIMIT;

endmodule

// File: tb/tb_pwm_clk_duty_src.sv
// Self-checking bench for pwm_clk_duty_src with a short PWM period (DIV=20, PERIOD=40).
module tb_pwm_clk_duty_src;

    localparam int DIV        = 20;
    localparam int PERIOD     = 40;
    localparam int LOCK_TICKS = 16;
    localparam int DUTY_RESET = 0;
    localparam int DUTY_W     = 13;

    logic              clk_in = 1'b0;
    logic              rst_n  = 1'b0;
    logic              duty_wr_en = 1'b0;
    logic [DUTY_W-1:0] duty_wr_data = '0;
    logic              tick_5mhz;
    logic              period_start;
    logic [DUTY_W-1:0] duty_cnt;
    logic              locked;

    int n_checks = 0;
    int n_errors = 0;

    pwm_clk_duty_src #(
        .CLK_IN_HZ  (100_000_000),
        .TICK_HZ    (5_000_000),
        .PERIOD     (PERIOD),
        .DUTY_RESET (DUTY_RESET),
        .LOCK_TICKS (LOCK_TICKS)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_data (duty_wr_data),
        .tick_5mhz    (tick_5mhz),
        .period_start (period_start),
        .duty_cnt     (duty_cnt),
        .locked       (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Model of the rules, indexed by k = clock edges since reset release.
    function automatic bit is_tick(input int k);
        return (k > 0) && (k % DIV == 0);
    endfunction

    function automatic bit is_start(input int k);
        return is_tick(k) && (((k / DIV) - 1) % PERIOD == 0);
    endfunction

    function automatic bit is_locked(input int k);
        return k >= DIV * LOCK_TICKS + 1;
    endfunction

    function automatic int stored_duty(input int req);
`ifdef DUTY_CLAMP_EN
        return (req > PERIOD - 1) ? PERIOD - 1 : req;
`else
        return req;
`endif
    endfunction

    int m_k      = 0;
    int m_shadow = DUTY_RESET;
    int m_duty   = DUTY_RESET;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_k      <= 0;
            m_shadow <= DUTY_RESET;
            m_duty   <= DUTY_RESET;
        end else begin
            m_k <= m_k + 1;
            if (is_start(m_k + 1)) m_duty <= is_locked(m_k) ? m_shadow : DUTY_RESET;
            if (duty_wr_en) m_shadow <= stored_duty(int'(duty_wr_data));
        end
    end

    always @(negedge clk_in) begin
        check("cmp_tick",         32'(tick_5mhz),    32'(is_tick(m_k)));
        check("cmp_period_start", 32'(period_start), 32'(is_start(m_k)));
        check("cmp_locked",       32'(locked),       32'(is_locked(m_k)));
        check("cmp_duty_cnt",     32'(duty_cnt),     32'(is_locked(m_k) ? m_duty : DUTY_RESET));
    end

    task automatic goto(input int target);
        int guard = 0;
        while (m_k != target && guard < 20000) begin
            @(negedge clk_in);
            guard++;
        end
        if (m_k != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL goto_timeout: got cycle %0d expected %0d", m_k, target);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_tick",   32'(tick_5mhz),    32'd0);
        check("rst_locked", 32'(locked),       32'd0);
        check("rst_duty",   32'(duty_cnt),     32'(DUTY_RESET));
        rst_n = 1'b1;

        // Tick phase and lock timing
        goto(19);  check("tick_before_first", 32'(tick_5mhz), 32'd0);
        goto(20);  check("first_tick",        32'(tick_5mhz), 32'd1);
                   check("first_period",      32'(period_start), 32'd1);
        goto(21);  check("tick_one_wide",     32'(tick_5mhz), 32'd0);
        goto(40);  check("second_tick",       32'(tick_5mhz), 32'd1);
                   check("no_period_mid",     32'(period_start), 32'd0);
        goto(320); check("locked_at_320",     32'(locked), 32'd0);
        goto(321); check("locked_at_321",     32'(locked), 32'd1);

        // Mid-period write waits for the boundary
        goto(400);
        duty_wr_en = 1'b1; duty_wr_data = 13'd2500;
        @(negedge clk_in); duty_wr_en = 1'b0;
        goto(819); check("duty_before_bound", 32'(duty_cnt), 32'd0);
        goto(820); check("period_spacing",    32'(period_start), 32'd1);
                   check("duty_2500",         32'(duty_cnt), 32'd2500);

        // Write captured on the load edge goes to shadow only
        goto(1619);
        duty_wr_en = 1'b1; duty_wr_data = 13'd1000;
        @(negedge clk_in); duty_wr_en = 1'b0;
        check("boundary_write_old", 32'(duty_cnt), 32'd2500);
        goto(2420); check("boundary_write_new", 32'(duty_cnt), 32'd1000);

        // Out-of-range request
        goto(2499);
        duty_wr_en = 1'b1; duty_wr_data = 13'd6000;
        @(negedge clk_in); duty_wr_en = 1'b0;
        goto(3220);
`ifdef DUTY_CLAMP_EN
        check("duty_6000_clamped", 32'(duty_cnt), 32'(PERIOD - 1));
`else
        check("duty_6000_raw", 32'(duty_cnt), 32'd6000);
`endif

        // Back-to-back writes: last one wins
        goto(3299);
        duty_wr_en = 1'b1; duty_wr_data = 13'd100;
        @(negedge clk_in); duty_wr_data = 13'd200;
        @(negedge clk_in); duty_wr_data = 13'd300;
        @(negedge clk_in); duty_wr_en = 1'b0;
        goto(4020); check("last_write_wins", 32'(duty_cnt), 32'd300);

        // Asynchronous reset in the middle of a tick
        goto(4100);
        #2 rst_n = 1'b0;
        #1;
        check("async_tick",   32'(tick_5mhz), 32'd0);
        check("async_locked", 32'(locked),    32'd0);
        check("async_duty",   32'(duty_cnt),  32'(DUTY_RESET));
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        goto(19);  check("rerst_no_tick",  32'(tick_5mhz), 32'd0);
        goto(20);  check("rerst_tick",     32'(tick_5mhz), 32'd1);
                   check("rerst_period",   32'(period_start), 32'd1);
        goto(321); check("rerst_locked",   32'(locked), 32'd1);
        goto(820); check("rerst_duty",     32'(duty_cnt), 32'(DUTY_RESET));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
